// File: rtl/game_pkg.sv
// game_pkg: shared defaults, background id and palette-entry type for the compositor
package game_pkg;

    localparam int DEF_NUM_LAYERS   = 8;
    localparam int DEF_COLOR_W      = 8;
    localparam int DEF_PAL_DEPTH    = 16;
    localparam int DEF_BLINK_FRAMES = 8;

    // Background takes the id one past the last layer
    localparam int BG_ID = DEF_NUM_LAYERS;

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } rgb_t;

    function automatic int bg_layer_id(input int num_layers);
        return num_layers;
    endfunction

endpackage

// File: rtl/palette_ram.sv
// palette_ram: register-based palette, one write port, one asynchronous read port
module palette_ram
    import game_pkg::*;
#(
    parameter int DEPTH  = DEF_PAL_DEPTH,
    parameter int DATA_W = 3 * DEF_COLOR_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Entry 0 resets to black, the rest to white; writes land at the clock edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= (k == 0) ? '0 : '1;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A read in the write cycle sees the old entry, since mem_q updates at the edge
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pixel_compositor.sv
// pixel_compositor: two-stage priority layer compositor with palette, blink and collision tracking
module pixel_compositor
    import game_pkg::*;
#(
    parameter int NUM_LAYERS   = DEF_NUM_LAYERS,
    parameter int COLOR_W      = DEF_COLOR_W,
    parameter int PAL_DEPTH    = DEF_PAL_DEPTH,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
    localparam int PIDX_W      = $clog2(PAL_DEPTH),
    localparam int LAYER_W     = $clog2(NUM_LAYERS) + 1
) (
    input  logic                               Clk,
    input  logic                               Reset_n,
    input  logic                               pix_valid,
    input  logic                               frame_start,
    input  logic [9:0]                         DrawX,
    input  logic [9:0]                         DrawY,
    input  logic [NUM_LAYERS-1:0]              layer_hit,
    input  logic [NUM_LAYERS-1:0][PIDX_W-1:0]  layer_pidx,
    input  logic [NUM_LAYERS-1:0]              layer_blink_en,
    input  logic [PIDX_W-1:0]                  bg_pidx,
    input  logic                               pal_wr_valid,
    input  logic [PIDX_W-1:0]                  pal_wr_idx,
    input  logic [3*COLOR_W-1:0]               pal_wr_rgb,
    output logic                               pal_wr_ready,
    output logic [COLOR_W-1:0]                 VGA_R,
    output logic [COLOR_W-1:0]                 VGA_G,
    output logic [COLOR_W-1:0]                 VGA_B,
    output logic                               out_valid,
    output logic [LAYER_W-1:0]                 out_layer,
    output logic [NUM_LAYERS-1:0]              collision_mask
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [LAYER_W-1:0] BG_LAYER = LAYER_W'(bg_layer_id(NUM_LAYERS));

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  blink_q, blink_d;
    logic [NUM_LAYERS-1:0] mhit;
    logic                  multi_hit;
    logic [LAYER_W-1:0]    sel_layer;
    logic [PIDX_W-1:0]     sel_pidx;
    logic [NUM_LAYERS-1:0] wmask_q, wmask_d;
    logic [NUM_LAYERS-1:0] coll_q, coll_d;
    logic                  s1_valid_q;
    logic [LAYER_W-1:0]    s1_layer_q;
    logic [PIDX_W-1:0]     s1_pidx_q;
    logic                  s2_valid_q;
    logic [LAYER_W-1:0]    s2_layer_q;
    logic [3*COLOR_W-1:0]  rgb_q, rgb_d;
    logic [3*COLOR_W-1:0]  pal_rdata;
    logic                  pal_we;
    logic                  unused_coords;

    assign unused_coords = ^{DrawX, DrawY};

    // Blinking layers vanish while the blink phase is high
    assign mhit      = layer_hit & ~(layer_blink_en & {NUM_LAYERS{blink_q}});
    assign multi_hit = |(mhit & (mhit - NUM_LAYERS'(1)));

    // Frame counter advances on frame_start; phase flips on wrap
    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (frame_start) begin
            cnt_d   = (cnt_q == CNT_W'(BLINK_FRAMES - 1)) ? '0 : cnt_q + 1'b1;
            blink_d = (cnt_q == CNT_W'(BLINK_FRAMES - 1)) ? ~blink_q : blink_q;
        end
    end

    // Lowest-index masked hit wins; scanning downward leaves the lowest one last
    always_comb begin
        sel_layer = BG_LAYER;
        sel_pidx  = bg_pidx;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (mhit[i]) begin
                sel_layer = LAYER_W'(i);
                sel_pidx  = layer_pidx[i];
            end
        end
    end

    // Overlapping layers accumulate per frame; frame_start publishes and restarts the mask
    always_comb begin
        wmask_d = (frame_start ? {NUM_LAYERS{1'b0}} : wmask_q)
                | ((pix_valid && multi_hit) ? mhit : {NUM_LAYERS{1'b0}});
        coll_d  = frame_start ? wmask_q : coll_q;
        rgb_d   = s1_valid_q ? pal_rdata : {3*COLOR_W{1'b0}};
    end

    // Pipeline, blink and collision state
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q      <= '0;
            blink_q    <= 1'b0;
            wmask_q    <= '0;
            coll_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_layer_q <= BG_LAYER;
            s1_pidx_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_layer_q <= BG_LAYER;
            rgb_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            blink_q    <= blink_d;
            wmask_q    <= wmask_d;
            coll_q     <= coll_d;
            s1_valid_q <= pix_valid;
            s1_layer_q <= sel_layer;
            s1_pidx_q  <= sel_pidx;
            s2_valid_q <= s1_valid_q;
            s2_layer_q <= s1_layer_q;
            rgb_q      <= rgb_d;
        end
    end

    // Palette writes are only accepted outside the active area
    assign pal_wr_ready = ~pix_valid;
    assign pal_we       = pal_wr_valid & ~pix_valid;

    palette_ram #(
        .DEPTH  (PAL_DEPTH),
        .DATA_W (3 * COLOR_W)
    ) u_palette (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .we_i    (pal_we),
        .waddr_i (pal_wr_idx),
        .wdata_i (pal_wr_rgb),
        .raddr_i (s1_pidx_q),
        .rdata_o (pal_rdata)
    );

    assign VGA_R          = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign VGA_G          = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign VGA_B          = rgb_q[COLOR_W-1:0];
    assign out_valid      = s2_valid_q;
    assign out_layer      = s2_layer_q;
    assign collision_mask = coll_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// tb_pixel_compositor: directed self-checking bench for pixel_compositor
module tb_pixel_compositor;
    import game_pkg::*;

    logic            Clk = 1'b0;
    logic            Reset_n;
    logic            pix_valid;
    logic            frame_start;
    logic [9:0]      DrawX, DrawY;
    logic [7:0]      layer_hit;
    logic [7:0][3:0] layer_pidx;
    logic [7:0]      layer_blink_en;
    logic [3:0]      bg_pidx;
    logic            pal_wr_valid;
    logic [3:0]      pal_wr_idx;
    logic [23:0]     pal_wr_rgb;
    logic            pal_wr_ready;
    logic [7:0]      VGA_R, VGA_G, VGA_B;
    logic            out_valid;
    logic [3:0]      out_layer;
    logic [7:0]      collision_mask;
    rgb_t            rgb;

    int checks   = 0;
    int failures = 0;

    pixel_compositor #(.BLINK_FRAMES(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .layer_hit(layer_hit), .layer_pidx(layer_pidx),
        .layer_blink_en(layer_blink_en), .bg_pidx(bg_pidx), .pal_wr_valid(pal_wr_valid),
        .pal_wr_idx(pal_wr_idx), .pal_wr_rgb(pal_wr_rgb), .pal_wr_ready(pal_wr_ready),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .out_valid(out_valid),
        .out_layer(out_layer), .collision_mask(collision_mask)
    );

    always #5 Clk = ~Clk;
    assign rgb = '{r: VGA_R, g: VGA_G, b: VGA_B};

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs;
        pix_valid = 0; frame_start = 0; layer_hit = 0; layer_blink_en = 0;
        layer_pidx = '0; bg_pidx = 0; pal_wr_valid = 0; pal_wr_idx = 0;
        pal_wr_rgb = 0; DrawX = 0; DrawY = 0;
    endtask

    task automatic do_reset;
        Reset_n = 0;
        idle_inputs();
        tick();
        tick();
        Reset_n = 1;
    endtask

    task automatic pal_write(input logic [3:0] idx, input logic [23:0] val);
        pix_valid = 0; pal_wr_valid = 1; pal_wr_idx = idx; pal_wr_rgb = val;
        tick();
        pal_wr_valid = 0;
    endtask

    task automatic pixel(input logic [7:0] hit);
        pix_valid = 1; layer_hit = hit; DrawX = DrawX + 1;
        tick();
        pix_valid = 0; layer_hit = 0;
        tick();
    endtask

    task automatic frame_pulse;
        frame_start = 1;
        tick();
        frame_start = 0;
    endtask

    task automatic test_reset;
        Reset_n = 0;
        idle_inputs();
        tick();
        checks++; if (rgb !== 24'h0) begin failures++; $display("FAIL reset_rgb got=%h want=000000", rgb); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        checks++; if (out_layer !== 4'd8) begin failures++; $display("FAIL reset_layer got=%0d want=8", out_layer); end
        checks++; if (collision_mask !== 8'h0) begin failures++; $display("FAIL reset_coll got=%h want=00", collision_mask); end
        pix_valid = 1; bg_pidx = 1;
        Reset_n = 1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid0 got=%b want=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid1 got=%b want=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL post_reset_valid2 got=%b want=1", out_valid); end
        checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("FAIL post_reset_rgb got=%h want=ffffff", rgb); end
        pix_valid = 0; bg_pidx = 0;
        tick();
    endtask

    task automatic test_priority;
        pal_write(4'd3, 24'h123456);
        layer_pidx[1] = 4'd3; layer_pidx[2] = 4'd7;
        pixel(8'b0000_0110);
        checks++; if (out_layer !== 4'd1) begin failures++; $display("FAIL prio_layer got=%0d want=1", out_layer); end
        checks++; if (rgb !== 24'h123456) begin failures++; $display("FAIL prio_rgb got=%h want=123456", rgb); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL prio_valid got=%b want=1", out_valid); end
        layer_pidx[7] = 4'd0;
        pixel(8'h80);
        checks++; if (out_layer !== 4'd7) begin failures++; $display("FAIL prio7_layer got=%0d want=7", out_layer); end
        checks++; if (rgb !== 24'h000000) begin failures++; $display("FAIL prio7_rgb got=%h want=000000", rgb); end
        layer_pidx[0] = 4'd3;
        pixel(8'hFF);
        checks++; if (out_layer !== 4'd0) begin failures++; $display("FAIL prio0_layer got=%0d want=0", out_layer); end
        checks++; if (rgb !== 24'h123456) begin failures++; $display("FAIL prio0_rgb got=%h want=123456", rgb); end
    endtask

    task automatic test_background;
        do_reset();
        bg_pidx = 0;
        pixel(8'h00);
        checks++; if (rgb !== 24'h000000) begin failures++; $display("FAIL bg0_rgb got=%h want=000000", rgb); end
        checks++; if (out_layer !== 4'd8) begin failures++; $display("FAIL bg0_layer got=%0d want=8", out_layer); end
        bg_pidx = 2;
        pixel(8'h00);
        checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("FAIL bg2_rgb got=%h want=ffffff", rgb); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL blank_valid got=%b want=0", out_valid); end
        checks++; if (rgb !== 24'h000000) begin failures++; $display("FAIL blank_rgb got=%h want=000000", rgb); end
    endtask

    task automatic test_palette_write;
        bg_pidx = 5; pix_valid = 1;
        pal_wr_valid = 1; pal_wr_idx = 5; pal_wr_rgb = 24'hFF0000;
        #1;
        checks++; if (pal_wr_ready !== 1'b0) begin failures++; $display("FAIL ready_active got=%b want=0", pal_wr_ready); end
        tick();
        pal_wr_valid = 0; pix_valid = 0;
        tick();
        checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("FAIL blocked_write_rgb got=%h want=ffffff", rgb); end
        pal_wr_valid = 1;
        #1;
        checks++; if (pal_wr_ready !== 1'b1) begin failures++; $display("FAIL ready_blank got=%b want=1", pal_wr_ready); end
        tick();
        pal_wr_valid = 0;
        pixel(8'h00);
        checks++; if (rgb !== 24'hFF0000) begin failures++; $display("FAIL written_rgb got=%h want=ff0000", rgb); end
    endtask

    task automatic test_read_during_write;
        bg_pidx = 6; pix_valid = 1;
        tick();
        pix_valid = 0;
        pal_wr_valid = 1; pal_wr_idx = 6; pal_wr_rgb = 24'h00FF00;
        tick();
        pal_wr_valid = 0;
        checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("FAIL rdw_old_rgb got=%h want=ffffff", rgb); end
        pixel(8'h00);
        checks++; if (rgb !== 24'h00FF00) begin failures++; $display("FAIL rdw_new_rgb got=%h want=00ff00", rgb); end
    endtask

    task automatic test_blink;
        int exp_layer [5];
        exp_layer = '{0, 0, 2, 2, 0};
        do_reset();
        layer_blink_en = 8'h01;
        for (int f = 0; f < 5; f++) begin
            pixel(8'h05);
            checks++;
            if (out_layer !== 4'(exp_layer[f])) begin
                failures++;
                $display("FAIL blink_frame%0d got=%0d want=%0d", f, out_layer, exp_layer[f]);
            end
            frame_pulse();
        end
        layer_blink_en = 8'h00;
    endtask

    task automatic test_collision;
        do_reset();
        pixel(8'h12);
        pixel(8'h08);
        pix_valid = 0; layer_hit = 8'hC0;
        tick();
        layer_hit = 0;
        checks++; if (collision_mask !== 8'h00) begin failures++; $display("FAIL coll_before got=%h want=00", collision_mask); end
        frame_pulse();
        checks++; if (collision_mask !== 8'h12) begin failures++; $display("FAIL coll_n1 got=%h want=12", collision_mask); end
        tick();
        frame_pulse();
        checks++; if (collision_mask !== 8'h00) begin failures++; $display("FAIL coll_n2 got=%h want=00", collision_mask); end
        frame_start = 1; pix_valid = 1; layer_hit = 8'h21;
        tick();
        frame_start = 0; pix_valid = 0; layer_hit = 0;
        checks++; if (collision_mask !== 8'h00) begin failures++; $display("FAIL coll_fs_cycle got=%h want=00", collision_mask); end
        frame_pulse();
        checks++; if (collision_mask !== 8'h21) begin failures++; $display("FAIL coll_fs_next got=%h want=21", collision_mask); end
    endtask

    task automatic test_async_reset;
        pal_write(4'd1, 24'h0A0B0C);
        pix_valid = 1; layer_hit = 8'h06;
        tick();
        pix_valid = 0; layer_hit = 0;
        frame_pulse();
        pix_valid = 1; bg_pidx = 1;
        tick();
        tick();
        checks++; if (rgb !== 24'h0A0B0C) begin failures++; $display("FAIL pre_reset_rgb got=%h want=0a0b0c", rgb); end
        checks++; if (collision_mask !== 8'h06) begin failures++; $display("FAIL pre_reset_coll got=%h want=06", collision_mask); end
        #2;
        Reset_n = 0;
        #1;
        checks++; if (rgb !== 24'h0) begin failures++; $display("FAIL async_rgb got=%h want=000000", rgb); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b want=0", out_valid); end
        checks++; if (out_layer !== 4'd8) begin failures++; $display("FAIL async_layer got=%0d want=8", out_layer); end
        checks++; if (collision_mask !== 8'h0) begin failures++; $display("FAIL async_coll got=%h want=00", collision_mask); end
        tick();
        Reset_n = 1;
        pix_valid = 0;
        pixel(8'h00);
        checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("FAIL pal1_after_reset got=%h want=ffffff", rgb); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_background();
        test_palette_write();
        test_read_during_write();
        test_blink();
        test_collision();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_compositor.md
PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 8: number of priority layers; layer 0 is highest priority.
REQ-002 SHALL have parameter COLOR_W, default 8: bits per colour channel.
REQ-003 SHALL have parameter PAL_DEPTH, default 16: palette entries, power of two; PIDX_W = log2(PAL_DEPTH).
REQ-004 SHALL have parameter BLINK_FRAMES, default 8: frames per blink half-period, at least 1.
REQ-005 SHALL have port Clk, input, 1: the single clock.
REQ-006 SHALL have port Reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port pix_valid, input, 1: DrawX/DrawY are in the active area this cycle.
REQ-008 SHALL have port frame_start, input, 1: one-cycle pulse at the first cycle of each frame.
REQ-009 SHALL have port DrawX and DrawY, input, 10 each: current pixel coordinates.
REQ-010 SHALL have port layer_hit, input, NUM_LAYERS: per-layer "pixel is opaque" flags.
REQ-011 SHALL have port layer_pidx, input, NUM_LAYERS x PIDX_W: per-layer palette index.
REQ-012 SHALL have port layer_blink_en, input, NUM_LAYERS: layer is subject to blinking.
REQ-013 SHALL have port bg_pidx, input, PIDX_W: background palette index.
REQ-014 SHALL have port pal_wr_valid, input, 1 plus pal_wr_idx, input, PIDX_W plus pal_wr_rgb, input, 3*COLOR_W as {R,G,B}: palette write request.
REQ-015 SHALL have port pal_wr_ready, output, 1: palette write accepted this cycle.
REQ-016 SHALL have port VGA_R, VGA_G and VGA_B, output, COLOR_W each: registered pixel colour.
REQ-017 SHALL have port out_valid, output, 1: pix_valid delayed 2 cycles.
REQ-018 SHALL have port out_layer, output, PIDX_W-independent width log2(NUM_LAYERS)+1: winning layer id; value NUM_LAYERS means background.
REQ-019 SHALL have port collision_mask, output, NUM_LAYERS: layers that overlapped another layer in the previous frame.

Function
REQ-020 SHALL compute a blink-masked hit per layer: hit AND NOT (blink_en AND blink_phase).
REQ-021 SHALL register, in stage 1, the lowest-index masked hit (or background), its palette index, and pix_valid.
REQ-022 SHALL look up the palette in stage 2 and register the RGB, out_layer and out_valid; latency is exactly 2 cycles.
REQ-023 SHALL output black (all zeros) on VGA_R/G/B whenever the stage-2 valid is 0.
REQ-024 SHALL keep a frame counter in the range 0..BLINK_FRAMES-1 that advances on frame_start; blink_phase toggles when the counter wraps from BLINK_FRAMES-1 to 0.
REQ-025 SHALL drive pal_wr_ready = NOT pix_valid; a write occurs only when valid and ready are both high, at that rising edge.
REQ-026 SHALL let a stage-2 read of the same index in the write cycle return the old entry; the new entry is visible from the next cycle.
REQ-027 SHALL OR into a working mask each layer whose masked hit is set while at least one other masked hit is set, evaluated only when pix_valid = 1.
REQ-028 SHALL, on frame_start, copy the working mask to collision_mask and clear the working mask in the same cycle; a collision on the frame_start cycle itself goes into the new working mask.
REQ-029 SHALL not stall or affect the pipeline through frame_start or palette writes.

Reset
REQ-030 SHALL, while Reset_n = 0 (asynchronously): clear the pipeline registers, VGA_R/G/B, out_valid, out_layer = NUM_LAYERS, collision_mask, the working mask, the frame counter and blink_phase.
REQ-031 SHALL reset the palette to entry 0 = black and all other entries = white (all ones).
REQ-032 SHALL give out_valid = 0 for the first 2 cycles after reset release, regardless of pix_valid.

Structure
REQ-033 SHALL place the default parameters, the background id constant and the palette-entry struct type {R,G,B} in the shared package game_pkg.
REQ-034 SHALL implement the registered palette storage as the sub-module palette_ram, with one write port and one read port.
REQ-035 SHALL realise the priority select as a parametrised loop; no per-layer hand-coded branches.

Verification
REQ-036 SHALL check: layer_hit = 0b00000110, pidx1 = 3, pix_valid = 1 -> two cycles later out_layer = 1 and RGB = palette[3].
REQ-037 SHALL check: no hits, bg_pidx = 0, after reset -> RGB = 000000 and out_layer = 8.
REQ-038 SHALL check: pal_wr_valid with pix_valid = 1 -> ready = 0 and palette unchanged; the same request with pix_valid = 0 -> entry 5 = FF0000 on the next cycle.
REQ-039 SHALL check: BLINK_FRAMES = 2, blink_en[0] = 1, layer 0 and layer 2 hit -> out_layer alternates 0,0,2,2 across 4 frames.
REQ-040 SHALL check: layers 1 and 4 overlap in one pixel of frame N -> collision_mask = 0b00010010 after frame N+1 frame_start, and 0 after frame N+2.
REQ-041 SHALL check: Reset_n asserted mid-line -> all outputs 0 immediately (asynchronous), and palette entry 1 = FFFFFF after reset.
